// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: multi-cycle fetch/decode/sequencer feeding the 8-bit accumulator ALU.
// Optional feature: define FD_CYCLE_COUNT_EN to add the saturating o_cycle_count output.
`default_nettype none

module instr_fetch_decode #(
  parameter int PC_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [8:0]      i_imem_data,
  input  logic            i_iszero,
  output logic [3:0]      o_op,
  output logic            o_flag,
  output logic [4:0]      o_imme,
  output logic [2:0]      o_rb_sel,
  output logic            o_acc_we,
  output logic            o_mem_re,
  output logic            o_mem_we,
  output logic            o_busy,
  output logic            o_done
`ifdef FD_CYCLE_COUNT_EN
  ,
  output logic [15:0]     o_cycle_count
`endif
);

  localparam logic [3:0] c_op_slt   = 4'd8;
  localparam logic [3:0] c_op_beo   = 4'd9;
  localparam logic [3:0] c_op_bez   = 4'd10;
  localparam logic [3:0] c_op_load  = 4'd11;
  localparam logic [3:0] c_op_store = 4'd12;
  localparam logic [3:0] c_op_or    = 4'd13;
  localparam logic [3:0] c_op_setf  = 4'd14;
  localparam logic [3:0] c_op_halt  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_ir;
  logic            r_flag;
  logic            w_acc_we;
  logic            w_mem_re;
  logic            w_mem_we;
  logic            w_start_ok;
  logic            w_taken;
  logic [3:0]      w_ir_op;
  logic [PC_W-1:0] w_offset;

  assign w_ir_op    = r_ir[8:5];
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_HALTED));
  assign w_taken    = ((w_ir_op == c_op_beo) || (w_ir_op == c_op_bez)) && i_iszero;
  assign w_offset   = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: if (i_start) w_state_nxt = S_FETCH;
      S_FETCH:          w_state_nxt = S_DECODE;
      S_DECODE:         w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_acc_we = (w_ir_op <= c_op_slt) || (w_ir_op == c_op_or);
        w_mem_we = (w_ir_op == c_op_store);
        if (w_ir_op == c_op_load) begin
          w_mem_re    = 1'b1;
          w_state_nxt = S_MEMWAIT;
        end else if (w_ir_op == c_op_halt) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        w_acc_we    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default:          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_pc   <= '0;
        r_flag <= 1'b0;
      end
      if (r_state == S_DECODE) r_ir <= i_imem_data;
      if (r_state == S_EXEC) begin
        if (w_ir_op == c_op_setf) r_flag <= r_ir[0];
        // HALT leaves the PC pointing at itself
        if (w_ir_op != c_op_halt) r_pc <= w_taken ? (r_pc + w_offset) : (r_pc + 1'b1);
      end
    end
  end

  always_comb begin
    o_op     = 4'd0;
    o_imme   = 5'd0;
    o_rb_sel = 3'd0;
    // During DECODE the fields come straight from the ROM so they are stable before IR loads
    if (r_state == S_DECODE) begin
      o_op     = i_imem_data[8:5];
      o_imme   = i_imem_data[4:0];
      o_rb_sel = i_imem_data[2:0];
    end else if ((r_state == S_EXEC) || (r_state == S_MEMWAIT)) begin
      o_op     = r_ir[8:5];
      o_imme   = r_ir[4:0];
      o_rb_sel = r_ir[2:0];
    end
  end

  assign o_imem_addr = r_pc;
  assign o_flag      = r_flag;
  assign o_acc_we    = w_acc_we;
  assign o_mem_re    = w_mem_re;
  assign o_mem_we    = w_mem_we;
  assign o_busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXEC)  || (r_state == S_MEMWAIT);
  assign o_done      = (r_state == S_HALTED);

`ifdef FD_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_count <= 16'd0;
    end else if (w_start_ok) begin
      r_cycle_count <= 16'd0;
    end else if (o_busy && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// Testbench for instr_fetch_decode: strobe scoreboard plus per-scenario timing checks.
`default_nettype none

module tb_instr_fetch_decode;
  localparam int PC_W = 8;
  localparam logic [8:0] SETF0 = 9'h1C0;
  localparam logic [8:0] HALT  = 9'h1E0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            iszero = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data = 9'd0;
  logic [3:0]      op;
  logic            flag;
  logic [4:0]      imme;
  logic [2:0]      rb_sel;
  logic            acc_we, mem_re, mem_we, busy, done;
`ifdef FD_CYCLE_COUNT_EN
  logic [15:0]     cycle_count;
`endif

  logic [8:0]  rom [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_got, mon_exp;

  instr_fetch_decode #(.PC_W(PC_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data), .i_iszero(iszero),
    .o_op(op), .o_flag(flag), .o_imme(imme), .o_rb_sel(rb_sel),
    .o_acc_we(acc_we), .o_mem_re(mem_re), .o_mem_we(mem_we),
    .o_busy(busy), .o_done(done)
`ifdef FD_CYCLE_COUNT_EN
    , .o_cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Strobe event: {acc,re,we}, op, imme, rb_sel, flag, cycle index since START
  function automatic logic [31:0] ev(input logic [2:0] k, input logic [3:0] o,
                                     input logic [4:0] im, input logic [2:0] rb,
                                     input logic f, input int c);
    logic [15:0] c16;
    c16 = c[15:0];
    return {k, o, im, rb, f, c16};
  endfunction

  function automatic logic [25:0] outs();
    return {imem_addr, op, flag, imme, rb_sel, acc_we, mem_re, mem_we, busy, done};
  endfunction

  always @(negedge clk) begin
    if (!rst && (acc_we || mem_re || mem_we)) begin
      mon_got = ev({acc_we, mem_re, mem_we}, op, imme, rb_sel, flag, cyc - start_cyc + 1);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL strobe_event got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = SETF0;
  endtask

  task automatic pulse_start(input bit restart);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (restart) start_cyc = cyc;
  endtask

  task automatic wait_cycle(input int k);
    do @(negedge clk); while (cyc - start_cyc + 1 < k);
  endtask

  task automatic wait_done(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        at = cyc - start_cyc + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int at; bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (outs() !== 26'd0) begin n_fail++; $display("FAIL reset_outs got=%h required=0", outs()); end
    rst = 1'b0;
    #1;
    n_checks++; if (outs() !== 26'd0) begin n_fail++; $display("FAIL idle_outs got=%h required=0", outs()); end
    fill_rom();
    rom[0] = {4'd1, 5'd3};
    rom[1] = HALT;
    exp_q.push_back(ev(3'b100, 4'd1, 5'd3, 3'd3, 1'b0, 3));
    pulse_start(1'b1);
    wait_cycle(3);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (outs() !== 26'd0) begin n_fail++; $display("FAIL reset_mid_exec got=%h required=0", outs()); end
`ifdef FD_CYCLE_COUNT_EN
    n_checks++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d required=0", cycle_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(ev(3'b100, 4'd1, 5'd3, 3'd3, 1'b0, 3));
    pulse_start(1'b1);
    n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL restart_addr got=%0d required=0", imem_addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b required=1", busy); end
    wait_done(50, at, ok);
    n_checks++; if (!ok || at != 7) begin n_fail++; $display("FAIL reset_done_cycle got=%0d required=7", at); end
  endtask

  task automatic test_sequencing();
    int at; bit ok;
    fill_rom();
    rom[0] = {4'd0, 5'd5};
    rom[1] = {4'd1, 5'd3};
    rom[2] = HALT;
    exp_q.push_back(ev(3'b100, 4'd0, 5'd5, 3'd5, 1'b0, 3));
    exp_q.push_back(ev(3'b100, 4'd1, 5'd3, 3'd3, 1'b0, 6));
    pulse_start(1'b1);
    wait_done(60, at, ok);
    n_checks++; if (!ok || at != 10) begin n_fail++; $display("FAIL seq_done_cycle got=%0d required=10", at); end
    n_checks++; if ({busy, op, imme, rb_sel} !== 13'd0) begin n_fail++; $display("FAIL halted_fields got=%h required=0", {busy, op, imme, rb_sel}); end
`ifdef FD_CYCLE_COUNT_EN
    n_checks++; if (cycle_count !== 16'd9) begin n_fail++; $display("FAIL seq_count got=%0d required=9", cycle_count); end
`endif
  endtask

  task automatic test_load_store();
    int at; bit ok;
    fill_rom();
    rom[0] = {4'd11, 5'd2};
    rom[1] = {4'd12, 5'd3};
    rom[2] = HALT;
    exp_q.push_back(ev(3'b010, 4'd11, 5'd2, 3'd2, 1'b0, 3));
    exp_q.push_back(ev(3'b100, 4'd11, 5'd2, 3'd2, 1'b0, 4));
    exp_q.push_back(ev(3'b001, 4'd12, 5'd3, 3'd3, 1'b0, 7));
    pulse_start(1'b1);
    wait_done(60, at, ok);
    n_checks++; if (!ok || at != 11) begin n_fail++; $display("FAIL ldst_done_cycle got=%0d required=11", at); end
`ifdef FD_CYCLE_COUNT_EN
    n_checks++; if (cycle_count !== 16'd10) begin n_fail++; $display("FAIL ldst_count got=%0d required=10", cycle_count); end
`endif
  endtask

  task automatic test_branch();
    int at; bit ok;
    fill_rom();
    rom[4] = {4'd10, 5'b11110};
    rom[5] = HALT;
    iszero = 1'b1;
    pulse_start(1'b1);
    wait_cycle(15);
    n_checks++; if ({op, imme} !== {4'd10, 5'd30}) begin n_fail++; $display("FAIL bez_fields got=%h required=%h", {op, imme}, {4'd10, 5'd30}); end
    wait_cycle(16);
    n_checks++; if (imem_addr !== 8'd2) begin n_fail++; $display("FAIL bez_taken got=%0d required=2", imem_addr); end
    iszero = 1'b0;
    wait_cycle(25);
    n_checks++; if (imem_addr !== 8'd5) begin n_fail++; $display("FAIL bez_not_taken got=%0d required=5", imem_addr); end
    wait_done(40, at, ok);
    n_checks++; if (!ok || at != 28) begin n_fail++; $display("FAIL branch_done_cycle got=%0d required=28", at); end
  endtask

  task automatic test_wrap();
    int at; bit ok;
    fill_rom();
    rom[2] = {4'd9, 5'b10000};
    rom[3] = HALT;
    iszero = 1'b1;
    pulse_start(1'b1);
    wait_cycle(10);
    n_checks++; if (imem_addr !== 8'd242) begin n_fail++; $display("FAIL beo_neg16 got=%0d required=242", imem_addr); end
    iszero = 1'b0;
    wait_cycle(51);
    n_checks++; if (imem_addr !== 8'd255) begin n_fail++; $display("FAIL pc_255 got=%0d required=255", imem_addr); end
    wait_cycle(52);
    n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL pc_wrap got=%0d required=0", imem_addr); end
    wait_cycle(61);
    n_checks++; if (imem_addr !== 8'd3) begin n_fail++; $display("FAIL beo_not_taken got=%0d required=3", imem_addr); end
    wait_done(20, at, ok);
    n_checks++; if (!ok || at != 64) begin n_fail++; $display("FAIL wrap_done_cycle got=%0d required=64", at); end
  endtask

  task automatic test_flag_start();
    int at; bit ok;
    fill_rom();
    rom[0] = {4'd14, 5'd1};
    rom[1] = {4'd4, 5'd2};
    rom[2] = HALT;
    exp_q.push_back(ev(3'b100, 4'd4, 5'd2, 3'd2, 1'b1, 6));
    pulse_start(1'b1);
    wait_cycle(2);
    pulse_start(1'b0);
    wait_cycle(4);
    n_checks++; if (imem_addr !== 8'd1) begin n_fail++; $display("FAIL start_while_busy got=%0d required=1", imem_addr); end
    wait_cycle(6);
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL flag_in_sl got=%b required=1", flag); end
    wait_done(40, at, ok);
    n_checks++; if (!ok || at != 10) begin n_fail++; $display("FAIL flag_done_cycle got=%0d required=10", at); end
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL flag_persist got=%b required=1", flag); end
    exp_q.push_back(ev(3'b100, 4'd4, 5'd2, 3'd2, 1'b1, 6));
    pulse_start(1'b1);
    n_checks++; if ({flag, done, busy, imem_addr} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL restart_after_halt got=%h required=%h", {flag, done, busy, imem_addr}, {1'b0, 1'b0, 1'b1, 8'd0});
    end
    wait_done(40, at, ok);
    n_checks++; if (!ok || at != 10) begin n_fail++; $display("FAIL rerun_done_cycle got=%0d required=10", at); end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_sequencing();
    test_load_store();
    test_branch();
    test_wrap();
    test_flag_start();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL strobe_missing got=%0d required=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Multi-cycle fetch/decode/sequencing stage sitting directly upstream of the 8-bit accumulator ALU. It walks the program counter over a synchronous instruction ROM, decodes each 9-bit instruction into the ALU's opcode, immediate and shift-direction inputs, and selects the register-file operand. It issues accumulator, register and data-memory strobes at the correct cycle and resolves BEO/BEZ branches from the ALU's zero output.

## Interface
- PC_W, 8, program counter / instruction ROM address width
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; starts execution at PC=0 from IDLE or HALTED
- IMEM_ADDR  out  PC_W  instruction ROM address (= PC)
- IMEM_DATA  in  9  instruction word; valid the cycle after IMEM_ADDR is presented
- ISZERO  in  1  ALU branch condition, sampled in EXEC
- OP  out  4  ALU opcode
- FLAG  out  1  shift direction to ALU (1 = right)
- IMME  out  5  immediate field to ALU
- RB_SEL  out  3  register-file read index feeding ALU INB
- ACC_WE  out  1  accumulator write strobe (ALU OUT -> ACC)
- MEM_RE  out  1  data-memory read strobe, address = R[RB_SEL]
- MEM_WE  out  1  data-memory write strobe, data = ACC, address = R[RB_SEL]
- BUSY  out  1  high from START accept until halt
- DONE  out  1  high in HALTED state

## Operation
- Instruction format: IR[8:5] = opcode, IR[4:0] = IMME; RB_SEL = IR[2:0].
- Opcode encoding: 0 MOVE, 1 ADDI, 2 ADDR, 3 SUBR, 4 SL, 5 SLR, 6 SNE, 7 SEQ, 8 SLT, 9 BEO, 10 BEZ, 11 LOAD, 12 STORE, 13 OR, 14 SETF, 15 HALT.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEMWAIT, HALTED.
- IDLE/HALTED --START--> FETCH, PC <= 0, FLAG <= 0. FETCH -> DECODE, which latches IR <= IMEM_DATA and then goes to EXEC.
- EXEC then transitions as follows:
  - LOAD -> MEMWAIT.
  - HALT -> HALTED, with PC unchanged.
  - All other opcodes -> FETCH.
- ACC_WE is asserted for exactly one cycle in EXEC for opcodes 0-8 and 13. For LOAD, ACC_WE is asserted in MEMWAIT instead.
- MEM_RE is asserted in EXEC for LOAD.
- MEM_WE is asserted in EXEC for STORE.
- SETF latches FLAG <= IMME[0]. FLAG persists until the next SETF or START.
- PC update in EXEC:
  - BEO/BEZ with ISZERO=1: PC <= PC + sign-extended IMME (range −16..+15).
  - Any other case: PC <= PC + 1.
- All PC arithmetic is modulo 2^PC_W and wraps silently; 255+1 = 0 and 2+(−16) = 242.
- OP/IMME/RB_SEL are driven from IR and held stable from DECODE through EXEC/MEMWAIT. They are 0 in IDLE and HALTED.
- START is ignored while BUSY.
- Opcode 15 is the only way to stop; a program without HALT runs indefinitely.

## Timing
- Non-LOAD instruction: 3 cycles (FETCH, DECODE, EXEC). LOAD: 4 cycles.
- First IMEM_ADDR=0 is presented in the FETCH cycle following the START edge.
- The branch decision uses ISZERO combinationally in the EXEC cycle. The new PC is visible on IMEM_ADDR in the next FETCH.
- DONE rises on the edge leaving EXEC of HALT and holds until START or RESET.
- RESET (any time, including mid-instruction) immediately drives the block to IDLE with:
  - PC=0, IR=0, FLAG=0.
  - All strobes, BUSY and DONE at 0; OP/IMME/RB_SEL at 0.
  - A pending MEM_WE/ACC_WE is dropped.
- Reset value of every output is 0.

## Configuration
- FD_CYCLE_COUNT_EN defined: adds output CYCLE_COUNT [15:0].
  - Cleared on START and on RESET.
  - Increments every cycle while BUSY and saturates at 16'hFFFF.
  - Holds its value in HALTED.
- FD_CYCLE_COUNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset/start: assert RESET mid-EXEC of ADDI. Expect all outputs 0 immediately. Then pulse START: IMEM_ADDR=0 next cycle, BUSY=1.
- Sequencing: ROM {MOVE 5, ADDI 3, HALT}:
  - ACC_WE pulses at cycles 3 and 6 with OP=0/IMME=5, then OP=1/IMME=3.
  - DONE=1 after cycle 9.
  - CYCLE_COUNT=9 when FD_CYCLE_COUNT_EN is defined.
- Load/store: ROM {LOAD r2, STORE r3, HALT}:
  - LOAD: MEM_RE in EXEC, then ACC_WE in MEMWAIT with RB_SEL=2, taking 4 cycles.
  - STORE: MEM_WE for one cycle with RB_SEL=3.
- Branch taken/not taken, BEZ IMME=5'b11110 at PC=4:
  - ISZERO=1 -> next IMEM_ADDR=2.
  - ISZERO=0 -> next IMEM_ADDR=5.
- Wrap-around: PC=255 non-branch -> next IMEM_ADDR=0. PC=2, BEO IMME=−16, ISZERO=1 -> 242.
- FLAG/START: SETF 1 then SL -> FLAG=1 during SL EXEC. START pulsed while BUSY is ignored (PC unaffected). START after HALT clears FLAG and DONE and restarts at PC=0.
